cdp_priority_encoder: RTL and testbench
=======================================

# cdp_priority_encoder

Parameterised priority encoder that reports the index of the highest-set request bit plus a valid flag. It provides two result paths from one request vector: a purely combinational path and a registered path, so callers can choose zero latency or a clean registered output. It sits in front of arbitration and interrupt logic that needs "highest active line" information.

## Interface

**Parameters**
- WIDTH, 4: number of request bits; legal values are 2 or more.
- OUT_W, $clog2(WIDTH): width of the encoded index; derived, not overridden.

**Ports**
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- in  input  WIDTH  request vector; bit WIDTH-1 has the highest priority.
- out_async  output  OUT_W  combinational index of the highest set bit of in.
- valid_async  output  1  combinational; 1 when any bit of in is set.
- out_sync  output  OUT_W  registered copy of out_async.
- valid_sync  output  1  registered copy of valid_async.

The block uses one clock. Reset is asynchronous and active-low (rst_n). Port names are clk and rst_n.

## Operation
- Priority is MSB-first. out = the largest i for which in[i] = 1.
- Lower set bits are ignored whenever a higher bit is set. Example: in = 4'b1100 gives out = 2'b11.
- If in = 0, then valid = 0 and out = 0. The index is forced to zero and is never left undefined or held.
- If any bit of in is set, valid = 1.
- The async path is pure combinational logic, with no latches and no dependence on clk or rst_n.
- The sync path uses the same encoding function. out_sync and valid_sync are loaded together on every rising clk edge while rst_n is high.
- No enable input: the sync registers update on every cycle.
- X or Z on in is outside the contract and gets no required behaviour.

## Timing
- Async path latency is 0 cycles. out_async and valid_async follow in within the same delta or cycle.
- Sync path latency is 1 cycle. Values present on in just before rising edge N appear on out_sync and valid_sync right after edge N, and hold until edge N+1.
- Reset values:
  - out_sync = 0 and valid_sync = 0, applied immediately when rst_n falls, with no clock required.
  - The async outputs are unaffected by reset.
- Release: the first rising edge with rst_n high loads the current in.
- Reset asserted mid-stream clears the sync outputs at once. Any capture pending at that moment is discarded.
- If in changes at the same time as an edge, the value sampled is the pre-edge value (standard setup semantics).
- out_sync and valid_sync must never disagree. Both come from the same edge, so valid_sync = 0 always pairs with out_sync = 0.

## Structure
- Shared package cdp_pkg holds:
  - a function returning the encoded index and valid flag for a WIDTH-bit vector, or a constant-width helper;
  - the OUT_W derivation.
- Natural sub-module: cdp_encode_comb, the combinational encoder (WIDTH parameter; ports in, out, valid).
  - The top level instantiates it once and drives both paths from its outputs.
  - The async outputs are the sub-module outputs wired straight through.
  - The sync outputs come from one OUT_W+1-bit register with asynchronous active-low clear.
- Build the encoder as a loop scanning from LSB to MSB, where the last set bit wins. This is synthesizable for any WIDTH. Do not hard-code a case statement.

## Test plan
- Reset: with rst_n low and in = 4'b1000, the async outputs are 11/1 and the sync outputs are 00/0. Release rst_n; after the first rising edge, the sync outputs are 11/1.
- Single-hot sweep: apply in = 1000, 0100, 0010, 0001, each held for one clock period. The async outputs are 11, 10, 01, 00 with valid 1. The sync outputs show the same values one edge later.
- Empty input: in = 4'b0000 gives async 00/0, and sync 00/0 after the next edge.
- Multiple bits: in = 4'b1100 gives 11/1, 4'b0111 gives 10/1, and 4'b1111 gives 11/1 on both paths (the sync path one edge later).
- Asynchronous reset mid-stream: with in = 4'b0100 and the sync outputs at 10/1, drop rst_n between edges. The sync outputs go to 00/0 immediately, and the async outputs stay at 10/1.
- Scaling: with WIDTH = 8 and OUT_W = 3, in = 8'b0010_0001 gives 101/1, and in = 0 gives 000/0.

Source files
------------

// File: rtl/cdp_pkg.sv
// Shared types and helpers for the cdp priority encoder: index-width derivation
// and an MSB-first encoding function over a fixed maximum vector width.
package cdp_pkg;

    localparam int MAX_W = 64;
    localparam int IDX_W = 6;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } enc_result_t;

    function automatic int out_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Scans LSB to MSB so the last (highest) set bit wins; an empty vector yields index 0.
    function automatic enc_result_t encode_msb(input logic [MAX_W-1:0] vec);
        enc_result_t r;
        r.valid = 1'b0;
        r.idx   = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            r.idx   = vec[i] ? IDX_W'(i) : r.idx;
            r.valid = r.valid | vec[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/cdp_encode_comb.sv
// Combinational MSB-first priority encoder; WIDTH may not exceed cdp_pkg::MAX_W.
module cdp_encode_comb
    import cdp_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int OUT_W = out_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    enc_result_t res_s;

    // Zero-extend the request into the shared encoder and narrow the index back down.
    always_comb begin
        res_s = encode_msb(MAX_W'(in));
        out   = OUT_W'(res_s.idx);
        valid = res_s.valid;
    end

endmodule

// File: rtl/cdp_priority_encoder.sv
// Priority encoder with a zero-latency combinational result and a one-cycle
// registered copy; both paths share a single encoder instance.
module cdp_priority_encoder
    import cdp_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int OUT_W = out_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out_async,
    output logic             valid_async,
    output logic [OUT_W-1:0] out_sync,
    output logic             valid_sync
);

    logic [OUT_W-1:0] out_s;
    logic             valid_s;
    logic [OUT_W:0]   sync_r;

    cdp_encode_comb #(
        .WIDTH (WIDTH)
    ) u_encode (
        .in    (in),
        .out   (out_s),
        .valid (valid_s)
    );

    assign out_async   = out_s;
    assign valid_async = valid_s;

    // Valid and index share one register so they can never come from different edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {(OUT_W + 1){1'b0}};
        end else begin
            sync_r <= {valid_s, out_s};
        end
    end

    assign out_sync   = sync_r[OUT_W-1:0];
    assign valid_sync = sync_r[OUT_W];

endmodule

// File: tb/tb_cdp_priority_encoder.sv
// Directed self-checking bench for cdp_priority_encoder at WIDTH=4 and WIDTH=8.
module tb_cdp_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] in4;
    logic [1:0] out_async4, out_sync4;
    logic       valid_async4, valid_sync4;
    logic [7:0] in8;
    logic [2:0] out_async8, out_sync8;
    logic       valid_async8, valid_sync8;

    int checks;
    int failures;

    cdp_priority_encoder #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in4),
        .out_async   (out_async4),
        .valid_async (valid_async4),
        .out_sync    (out_sync4),
        .valid_sync  (valid_sync4)
    );

    cdp_priority_encoder #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in8),
        .out_async   (out_async8),
        .valid_async (valid_async8),
        .out_sync    (out_sync8),
        .valid_sync  (valid_sync8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        in4   = 4'b1000;
        in8   = 8'h00;
        #3;
        checks++;
        if ({valid_async4, out_async4} !== 3'b1_11) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", {valid_async4, out_async4}, 3'b1_11);
        end
        checks++;
        if ({valid_sync4, out_sync4} !== 3'b0_00) begin
            failures++;
            $display("FAIL reset_sync got=%b exp=%b", {valid_sync4, out_sync4}, 3'b0_00);
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_sync4, out_sync4} !== 3'b0_00) begin
            failures++;
            $display("FAIL reset_held_sync got=%b exp=%b", {valid_sync4, out_sync4}, 3'b0_00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({valid_sync4, out_sync4} !== 3'b1_11) begin
            failures++;
            $display("FAIL release_sync got=%b exp=%b", {valid_sync4, out_sync4}, 3'b1_11);
        end
    endtask

    // Applies a vector at negedge: checks async now, sync still holds prev, then sync after the edge.
    task automatic apply4(input logic [3:0] v, input logic [2:0] exp, input logic [2:0] prev,
                          input string name);
        @(negedge clk);
        in4 = v;
        #1;
        checks++;
        if ({valid_async4, out_async4} !== exp) begin
            failures++;
            $display("FAIL %s_async in=%b got=%b exp=%b", name, v, {valid_async4, out_async4}, exp);
        end
        checks++;
        if ({valid_sync4, out_sync4} !== prev) begin
            failures++;
            $display("FAIL %s_latency in=%b got=%b exp=%b", name, v, {valid_sync4, out_sync4}, prev);
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_sync4, out_sync4} !== exp) begin
            failures++;
            $display("FAIL %s_sync in=%b got=%b exp=%b", name, v, {valid_sync4, out_sync4}, exp);
        end
    endtask

    task automatic test_single_hot();
        apply4(4'b1000, 3'b1_11, 3'b1_11, "hot3");
        apply4(4'b0100, 3'b1_10, 3'b1_11, "hot2");
        apply4(4'b0010, 3'b1_01, 3'b1_10, "hot1");
        apply4(4'b0001, 3'b1_00, 3'b1_01, "hot0");
    endtask

    task automatic test_empty();
        apply4(4'b0000, 3'b0_00, 3'b1_00, "empty");
    endtask

    task automatic test_multi_bits();
        apply4(4'b1100, 3'b1_11, 3'b0_00, "m1100");
        apply4(4'b0111, 3'b1_10, 3'b1_11, "m0111");
        apply4(4'b1111, 3'b1_11, 3'b1_10, "m1111");
        apply4(4'b0011, 3'b1_01, 3'b1_11, "m0011");
    endtask

    task automatic test_async_reset();
        apply4(4'b0100, 3'b1_10, 3'b1_01, "pre_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_sync4, out_sync4} !== 3'b0_00) begin
            failures++;
            $display("FAIL midrst_sync got=%b exp=%b", {valid_sync4, out_sync4}, 3'b0_00);
        end
        checks++;
        if ({valid_async4, out_async4} !== 3'b1_10) begin
            failures++;
            $display("FAIL midrst_async got=%b exp=%b", {valid_async4, out_async4}, 3'b1_10);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({valid_sync4, out_sync4} !== 3'b1_10) begin
            failures++;
            $display("FAIL midrst_release got=%b exp=%b", {valid_sync4, out_sync4}, 3'b1_10);
        end
    endtask

    task automatic test_scaling();
        logic [7:0] vecs [4];
        logic [3:0] exps [4];
        vecs = '{8'b0010_0001, 8'b0000_0000, 8'b1000_0001, 8'b0000_0010};
        exps = '{4'b1_101, 4'b0_000, 4'b1_111, 4'b1_001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in8 = vecs[i];
            #1;
            checks++;
            if ({valid_async8, out_async8} !== exps[i]) begin
                failures++;
                $display("FAIL w8_async in=%b got=%b exp=%b", vecs[i], {valid_async8, out_async8}, exps[i]);
            end
            @(posedge clk); #1;
            checks++;
            if ({valid_sync8, out_sync8} !== exps[i]) begin
                failures++;
                $display("FAIL w8_sync in=%b got=%b exp=%b", vecs[i], {valid_sync8, out_sync8}, exps[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_hot();
        test_empty();
        test_multi_bits();
        test_async_reset();
        test_scaling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
